// File: rtl/serial_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
//   tx_state_t : FSM state encoding
//   LINE_IDLE  : resting level of the serial line
//   cnt_width  : counter width helper, never narrower than one bit
package serial_pattern_pkg;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_PRE0  = 3'd1,
        TX_PRE1  = 3'd2,
        TX_SHIFT = 3'd3,
        TX_GAP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, shift-left register feeding the serial line MSB-first.
//   clk, reset : clock, asynchronous active-high reset (clears to 0)
//   load       : capture din (takes priority over shift)
//   shift      : shift left by one, filling with 0
//   din        : parallel word
//   msb        : current most significant bit
module piso_shreg
    import serial_pattern_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter: accepts a word on a valid/ready handshake and
// shifts it out MSB-first on an idle-high line, followed by GAP_CYCLES idle cycles.
// Build option: SERIAL_PATTERN_TX_PREAMBLE_EN inserts a 0,1 preamble before each frame.
//   clk, reset : clock, asynchronous active-high reset
//   din        : parallel word (WIDTH bits)
//   din_valid  : din holds a valid word
//   din_ready  : word can be accepted this cycle
//   a          : serial line, idle 1
//   busy       : frame or gap in progress
//   done       : one-cycle pulse after the last data bit
//
// state    | meaning
// ---------+------------------------------------------
// TX_IDLE  | line idle, ready for a word
// TX_PRE0  | preamble low bit
// TX_PRE1  | preamble high bit
// TX_SHIFT | data bits on the line, MSB first
// TX_GAP   | forced idle-high cycles after a frame
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             a,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    tx_state_t       state, state_nxt;
    logic [CW-1:0]   bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            done_q;
    logic            load, shift, msb, last_bit;

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (din),
        .msb   (msb)
    );

    assign last_bit = (state == TX_SHIFT) && (bit_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TX_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= last_bit;
            if (load) begin
                bit_cnt <= BIT_LOAD;
            end else if (shift && bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (last_bit) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == TX_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        a         = LINE_IDLE;
        case (state)
            TX_IDLE: begin
                if (din_valid) begin
                    load = 1'b1;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
                    state_nxt = TX_PRE0;
`else
                    state_nxt = TX_SHIFT;
`endif
                end
            end
            TX_PRE0: begin
                a         = 1'b0;
                state_nxt = TX_PRE1;
            end
            TX_PRE1: begin
                state_nxt = TX_SHIFT;
            end
            TX_SHIFT: begin
                a     = msb;
                shift = 1'b1;
                if (bit_cnt == '0) begin
                    state_nxt = (GAP_CYCLES > 0) ? TX_GAP : TX_IDLE;
                end
            end
            TX_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = TX_IDLE;
                end
            end
            default: begin
                state_nxt = TX_IDLE;
            end
        endcase
    end

    // Ready is held low while reset is asserted even though the state already reads idle.
    assign din_ready = (state == TX_IDLE) && !reset;
    assign busy      = (state != TX_IDLE);
    assign done      = done_q;

endmodule
